// File: rtl/div_pkg.sv
// Shared constants and FSM state type for the divider / reconstruction-multiplier pair.
package div_pkg;

    localparam int QW    = 40;
    localparam int DW    = 32;
    localparam int FRAC  = 8;
    localparam int PW    = QW + DW;
    localparam int CNT_W = $clog2(QW);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/recon_multiplier_adder33.sv
// Unsigned W+W add with carry-out; the per-iteration adder of the shift-add multiplier.
module adder33 #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W:0]   o_sum
);

    assign o_sum = {1'b0, i_a} + {1'b0, i_b};

endmodule

// File: rtl/recon_multiplier.sv
// Sequential shift-add multiplier rebuilding the dividend from a Q32.8 quotient and divisor,
// one quotient bit per clock, LSB first.
module recon_multiplier
    import div_pkg::*;
#(
    parameter int QW   = div_pkg::QW,
    parameter int DW   = div_pkg::DW,
    parameter int FRAC = div_pkg::FRAC
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [QW-1:0]        q,
    input  logic [DW-1:0]        ds,
    output logic                 busy,
    output logic                 done,
    output logic [QW+DW-1:0]     p,
    output logic [DW-1:0]        d_rec,
    output logic                 ovf
);

    localparam int PROD_W = QW + DW;
    localparam int CW     = $clog2(QW);

    state_t              r_state;
    logic [CW-1:0]       r_cnt;
    logic [DW-1:0]       r_hi;
    logic [QW-1:0]       r_mq;
    logic [DW-1:0]       r_ds;
    logic [PROD_W-1:0]   r_p;

    logic [DW-1:0]       w_addend;
    logic [DW:0]         w_sum;
    logic [PROD_W-1:0]   w_next;
    logic                w_last;

    assign w_addend = r_mq[0] ? r_ds : '0;

    adder33 #(.W(DW)) u_add (
        .i_a   (r_hi),
        .i_b   (w_addend),
        .o_sum (w_sum)
    );

    // Carry lands in the top bit of hi; the consumed multiplier bit shifts out of mq.
    assign w_next = {w_sum, r_mq[QW-1:1]};
    assign w_last = (r_cnt == CW'(QW - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_mq    <= '0;
            r_ds    <= '0;
            r_p     <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_mq    <= q;
                        r_ds    <= ds;
                        r_hi    <= '0;
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    {r_hi, r_mq} <= w_next;
                    if (w_last) begin
                        r_p     <= w_next;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy  = (r_state == RUN);
    assign done  = (r_state == DONE);
    assign p     = r_p;
    assign d_rec = r_p[QW-1:FRAC];
    assign ovf   = |r_p[PROD_W-1:QW];

endmodule

// File: tb/tb_recon_multiplier.sv
// Self-checking bench for recon_multiplier against a plain-arithmetic product model.
module tb_recon_multiplier;

    logic         clk;
    logic         rst;
    logic         start;
    logic [39:0]  q;
    logic [31:0]  ds;
    logic         busy;
    logic         done;
    logic [71:0]  p;
    logic [31:0]  d_rec;
    logic         ovf;

    int tests_run;
    int tests_failed;
    logic [71:0] exp_last;

    recon_multiplier #(.QW(40), .DW(32), .FRAC(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .q     (q),
        .ds    (ds),
        .busy  (busy),
        .done  (done),
        .p     (p),
        .d_rec (d_rec),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [71:0] model_p(input logic [39:0] mq, input logic [31:0] md);
        logic [71:0] a;
        logic [71:0] b;
        a = {32'd0, mq};
        b = {40'd0, md};
        return a * b;
    endfunction

    function automatic logic [31:0] model_drec(input logic [71:0] prod);
        logic [71:0] t;
        t = prod / 72'd256;
        return t[31:0];
    endfunction

    function automatic logic model_ovf(input logic [71:0] prod);
        return prod >= (72'd1 << 40);
    endfunction

    // Drive a one-cycle start; returns #1 after the accepting edge.
    task automatic issue(input logic [39:0] iq, input logic [31:0] ids);
        q     = iq;
        ds    = ids;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count edges until done is seen; -1 if it never arrives.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        q     = '0;
        ds    = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        tests_run++;
        if ({busy, done, ovf} !== 3'b000 || p !== 72'd0 || d_rec !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_state: busy=%b done=%b ovf=%b p=%h d_rec=%h, required all zero",
                     busy, done, ovf, p, d_rec);
        end
        exp_last = '0;
    endtask

    task automatic run_and_check(input string name, input logic [39:0] iq, input logic [31:0] ids);
        logic [71:0] e;
        int lat;
        e = model_p(iq, ids);
        issue(iq, ids);
        tests_run++;
        if (busy !== 1'b1 || p !== exp_last) begin
            tests_failed++;
            $display("FAIL %s_busy_hold: busy=%b p=%h, required busy=1 p=%h", name, busy, p, exp_last);
        end
        wait_done(lat);
        tests_run++;
        if (lat !== 40) begin
            tests_failed++;
            $display("FAIL %s_latency: got %0d, required 40", name, lat);
        end
        tests_run++;
        if (p !== e || d_rec !== model_drec(e) || ovf !== model_ovf(e) || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_result: p=%h d_rec=%h ovf=%b busy=%b, required p=%h d_rec=%h ovf=%b busy=0",
                     name, p, d_rec, ovf, busy, e, model_drec(e), model_ovf(e));
        end
        exp_last = e;
        @(posedge clk);
        #1;
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_done_pulse: done=%b busy=%b one cycle later, required 0/0", name, done, busy);
        end
    endtask

    task automatic test_directed();
        run_and_check("div100by7", 40'h0000000E49, 32'd7);
        tests_run++;
        if (p !== 72'h63FF || d_rec !== 32'd99 || ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL div100by7_const: p=%h d_rec=%0d ovf=%b, required 63ff 99 0", p, d_rec, ovf);
        end
        run_and_check("all_ones", 40'hFFFFFFFFFF, 32'hFFFFFFFF);
        tests_run++;
        if (p !== 72'hFFFFFFFEFF00000001 || d_rec !== 32'hFF000000 || ovf !== 1'b1) begin
            tests_failed++;
            $display("FAIL all_ones_const: p=%h d_rec=%h ovf=%b, required fffffffeff00000001 ff000000 1",
                     p, d_rec, ovf);
        end
        run_and_check("ds_zero", 40'h1234567890, 32'd0);
        run_and_check("q_zero", 40'd0, 32'hDEADBEEF);
    endtask

    task automatic test_random();
        logic [39:0] rq;
        logic [31:0] rd;
        for (int k = 0; k < 8; k++) begin
            rq = {$urandom, $urandom};
            rd = $urandom;
            if (k % 3 == 0) rq = rq & 40'h00000FFFFF;
            run_and_check("random", rq, rd);
        end
    endtask

    task automatic test_ignore_start();
        logic [71:0] e;
        int lat;
        e = model_p(40'h00000A5A00, 32'h12345);
        issue(40'h00000A5A00, 32'h12345);
        lat = -1;
        for (int i = 1; i <= 60; i++) begin
            if (i == 5 || i == 20) begin
                q     = {$urandom, $urandom};
                ds    = $urandom | 32'h1;
                start = 1'b1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                lat = i;
                break;
            end
            if (i == 6 || i == 21) begin
                tests_run++;
                if (p !== exp_last || busy !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL ignore_hold_c%0d: p=%h busy=%b, required p=%h busy=1", i, p, busy, exp_last);
                end
            end
        end
        tests_run++;
        if (lat !== 40 || p !== e) begin
            tests_failed++;
            $display("FAIL ignore_result: lat=%0d p=%h, required lat=40 p=%h", lat, p, e);
        end
        exp_last = e;
        @(posedge clk);
        #1;
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL ignore_after: done=%b busy=%b, required 0/0", done, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [71:0] ea;
        logic [71:0] eb;
        int lat;
        ea = model_p(40'h00000123AB, 32'h00FF00FF);
        eb = model_p(40'h8000000001, 32'hCAFEBABE);
        issue(40'h00000123AB, 32'h00FF00FF);
        wait_done(lat);
        tests_run++;
        if (lat !== 40 || p !== ea) begin
            tests_failed++;
            $display("FAIL b2b_first: lat=%0d p=%h, required lat=40 p=%h", lat, p, ea);
        end
        issue(40'h8000000001, 32'hCAFEBABE);
        tests_run++;
        if (busy !== 1'b1 || done !== 1'b0 || p !== ea) begin
            tests_failed++;
            $display("FAIL b2b_accept: busy=%b done=%b p=%h, required busy=1 done=0 p=%h", busy, done, p, ea);
        end
        wait_done(lat);
        tests_run++;
        if (lat !== 40 || p !== eb || ovf !== model_ovf(eb)) begin
            tests_failed++;
            $display("FAIL b2b_second: lat=%0d p=%h ovf=%b, required lat=40 p=%h ovf=%b",
                     lat, p, ovf, eb, model_ovf(eb));
        end
        exp_last = eb;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midrun();
        int seen_done;
        issue(40'h0000FFFF00, 32'h0000BEEF);
        repeat (20) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || p !== 72'd0 || d_rec !== 32'd0 || ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrun_reset_async: busy=%b done=%b p=%h d_rec=%h ovf=%b, required all zero",
                     busy, done, p, d_rec, ovf);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_last = '0;
        seen_done = 0;
        for (int i = 0; i < 45; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) seen_done++;
        end
        tests_run++;
        if (seen_done !== 0) begin
            tests_failed++;
            $display("FAIL midrun_no_done: %0d active cycles after reset, required 0", seen_done);
        end
        run_and_check("post_reset", 40'h100, 32'd5);
        tests_run++;
        if (d_rec !== 32'd5) begin
            tests_failed++;
            $display("FAIL post_reset_drec: d_rec=%0d, required 5", d_rec);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
